// File: rtl/program_sequencer.sv
// SIMT program sequencer: fetches 16-bit words, broadcasts them to cell cores and
// handles JMP/CALL/RET/BRD/HALT. Optional issue counter via PROGRAM_SEQUENCER_INSTR_COUNT_EN.
module program_sequencer #(
   parameter int PC_LENGTH = 12,
   parameter int SP_LENGTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 imem_req,
   output logic [PC_LENGTH-1:0] imem_addr,
   input  logic                 imem_valid,
   input  logic [15:0]          imem_data,
   output logic [15:0]          instruction,
   output logic [PC_LENGTH-1:0] next_program_counter,
   output logic [SP_LENGTH-1:0] next_stack_pointer,
   output logic                 execution_enable,
   input  logic                 diverge_any,
   output logic                 halted,
   output logic                 stack_error,
   output logic [31:0]          instr_count
);

   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_COND, HALT} state_t;

   state_t               state;
   logic [PC_LENGTH-1:0] pc;
   logic [SP_LENGTH-1:0] sp;
   logic [PC_LENGTH-1:0] stack [2**SP_LENGTH];

   logic [15:0]          word;
   logic [3:0]           op;
   logic [PC_LENGTH-1:0] target, pc_inc, dec_npc;
   logic [SP_LENGTH-1:0] dec_nsp;
   logic                 is_jmp, is_call, is_ret, is_brd, is_halt, dec_err;

   // One decoder serves both the fetch-accept edge and the ISSUE cycle; pc/sp
   // do not move in between, so both evaluations agree.
   always_comb begin
      word    = (state == FETCH) ? imem_data : instruction;
      op      = word[15:12];
      target  = PC_LENGTH'(word[11:0]);
      pc_inc  = pc + PC_LENGTH'(1);
      is_jmp  = (op == 4'hC);
      is_call = (op == 4'hD);
      is_brd  = (op == 4'hB);
      is_halt = (op == 4'hE) && (word[11:0] == 12'd0);
      is_ret  = (op == 4'hE) && (word[11:0] == 12'd1);
      dec_err = (is_call && (sp == '1)) || (is_ret && (sp == '0));
      dec_npc = pc_inc;
      dec_nsp = sp;
      if (dec_err) begin
         dec_npc = pc;
      end else if (is_jmp) begin
         dec_npc = target;
      end else if (is_call) begin
         dec_npc = target;
         dec_nsp = sp + SP_LENGTH'(1);
      end else if (is_ret) begin
         dec_npc = stack[sp - SP_LENGTH'(1)];
         dec_nsp = sp - SP_LENGTH'(1);
      end
   end

   // Stack storage carries no reset; only a legal CALL in ISSUE writes it.
   always_ff @(posedge clk) begin
      if (state == ISSUE && is_call && !dec_err)
         stack[sp] <= pc_inc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= IDLE;
         pc                   <= '0;
         sp                   <= '0;
         instruction          <= '0;
         execution_enable     <= 1'b0;
         imem_req             <= 1'b0;
         imem_addr            <= '0;
         next_program_counter <= '0;
         next_stack_pointer   <= '0;
         halted               <= 1'b0;
         stack_error          <= 1'b0;
      end else begin
         execution_enable <= 1'b0;
         case (state)
            IDLE: if (start) begin
               pc        <= '0;
               sp        <= '0;
               imem_req  <= 1'b1;
               imem_addr <= '0;
               state     <= FETCH;
            end
            FETCH: if (imem_valid) begin
               imem_req             <= 1'b0;
               instruction          <= imem_data;
               next_program_counter <= dec_npc;
               next_stack_pointer   <= dec_nsp;
               execution_enable     <= !dec_err;
               if (dec_err) stack_error <= 1'b1;
               state                <= ISSUE;
            end
            ISSUE: begin
               if (dec_err || is_halt) begin
                  halted <= 1'b1;
                  state  <= HALT;
               end else if (is_brd) begin
                  state <= WAIT_COND;
               end else begin
                  pc        <= dec_npc;
                  sp        <= dec_nsp;
                  imem_req  <= 1'b1;
                  imem_addr <= dec_npc;
                  state     <= FETCH;
               end
            end
            WAIT_COND: begin
               pc        <= diverge_any ? target : pc_inc;
               imem_addr <= diverge_any ? target : pc_inc;
               imem_req  <= 1'b1;
               state     <= FETCH;
            end
            HALT: if (start) begin
               halted      <= 1'b0;
               stack_error <= 1'b0;
               pc          <= '0;
               sp          <= '0;
               imem_req    <= 1'b1;
               imem_addr   <= '0;
               state       <= FETCH;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PROGRAM_SEQUENCER_INSTR_COUNT_EN
   logic [31:0] icnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         icnt <= '0;
      else if (start && (state == IDLE || state == HALT))
         icnt <= '0;
      else if (execution_enable)
         icnt <= icnt + 32'd1;
   end
   assign instr_count = icnt;
`else
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: expected issues and fetch addresses are
// queued per program and retired as the DUT strobes / requests.
module tb_program_sequencer;

   localparam int PCL = 12;
   localparam int SPL = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            imem_req;
   logic [PCL-1:0]  imem_addr;
   logic            imem_valid;
   logic [15:0]     imem_data;
   logic [15:0]     instruction;
   logic [PCL-1:0]  next_program_counter;
   logic [SPL-1:0]  next_stack_pointer;
   logic            execution_enable;
   logic            diverge_any;
   logic            halted;
   logic            stack_error;
   logic [31:0]     instr_count;

   program_sequencer #(.PC_LENGTH(PCL), .SP_LENGTH(SPL)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data),
      .instruction(instruction), .next_program_counter(next_program_counter),
      .next_stack_pointer(next_stack_pointer), .execution_enable(execution_enable),
      .diverge_any(diverge_any), .halted(halted), .stack_error(stack_error),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] ins;
      int          npc;
      int          nsp;
   } exp_t;

   exp_t        sb[$];
   int          fq[$];
   logic [15:0] mem [0:4095];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_strobe = 0;
   bit          mem_en = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [15:0] ins, input int npc, input int nsp);
      exp_t e;
      e.ins = ins; e.npc = npc; e.nsp = nsp;
      sb.push_back(e);
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 4096; a++) mem[a] = 16'hE000;
      sb.delete();
      fq.delete();
   endtask

   // Instruction memory: answers one cycle after a request is seen.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_en && imem_req && !rst) begin
            if (fq.size() == 0) chk("fetch_extra", 32'(imem_addr), 32'hFFFF_FFFF);
            else chk("fetch_addr", 32'(imem_addr), 32'(fq.pop_front()));
            imem_data  = mem[imem_addr];
            imem_valid = 1'b1;
         end else begin
            imem_valid = 1'b0;
         end
      end
   end

   // Issue monitor: every strobe retires one scoreboard entry.
   initial begin
      forever begin
         @(negedge clk);
         if (execution_enable) begin
            exp_t e;
            n_strobe++;
`ifndef PROGRAM_SEQUENCER_INSTR_COUNT_EN
            chk("icnt_zero", instr_count, 32'd0);
`endif
            if (sb.size() == 0) begin
               chk("issue_extra", 32'(instruction), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("issue_ins", 32'(instruction), 32'(e.ins));
               chk("issue_npc", 32'(next_program_counter), 32'(e.npc));
               chk("issue_nsp", 32'(next_stack_pointer), 32'(e.nsp));
            end
         end
      end
   end

   task automatic run(input string tag, input int exp_n, input logic exp_err);
      int cyc;
      n_strobe = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!halted && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_halted"}, 32'(halted), 32'd1);
      chk({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
      chk({tag, "_fq_left"}, 32'(fq.size()), 32'd0);
      chk({tag, "_n_issue"}, 32'(n_strobe), 32'(exp_n));
      chk({tag, "_stk_err"}, 32'(stack_error), 32'(exp_err));
      chk({tag, "_req_off"}, 32'(imem_req), 32'd0);
`ifdef PROGRAM_SEQUENCER_INSTR_COUNT_EN
      chk({tag, "_icnt"}, instr_count, 32'(exp_n));
`else
      chk({tag, "_icnt"}, instr_count, 32'd0);
`endif
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; imem_valid = 1'b0; imem_data = '0; diverge_any = 1'b0;
      clear_mem();
      #23;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_exe", 32'(execution_enable), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_npc", 32'(next_program_counter), 32'd0);
      chk("rst_icnt", instr_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // straight line then HALT
      mem[0] = 16'h1000; mem[1] = 16'h2000; mem[2] = 16'hE000;
      push(16'h1000, 1, 0); push(16'h2000, 2, 0); push(16'hE000, 3, 0);
      fq = '{0, 1, 2};
      run("lin", 3, 1'b0);

      // CALL 0x010 from PC 5, RET back to 6
      clear_mem();
      mem[0] = 16'hC005; mem[5] = 16'hD010; mem[16'h10] = 16'hE001; mem[6] = 16'hE000;
      push(16'hC005, 5, 0); push(16'hD010, 16'h10, 1); push(16'hE001, 6, 0); push(16'hE000, 7, 0);
      fq = '{0, 5, 16'h10, 6};
      run("call", 4, 1'b0);

      // BRD taken / not taken
      for (int d = 1; d >= 0; d--) begin
         clear_mem();
         diverge_any = d[0];
         mem[0] = 16'hC003; mem[3] = 16'hB020;
         push(16'hC003, 3, 0); push(16'hB020, 4, 0);
         if (d == 1) begin
            push(16'hE000, 16'h21, 0);
            fq = '{0, 3, 16'h20};
         end else begin
            push(16'hE000, 5, 0);
            fq = '{0, 3, 4};
         end
         run(d ? "brd1" : "brd0", 3, 1'b0);
      end
      diverge_any = 1'b0;

      // four nested CALLs on a 4-deep stack
      clear_mem();
      mem[0] = 16'hD001; mem[1] = 16'hD002; mem[2] = 16'hD003; mem[3] = 16'hD004;
      push(16'hD001, 1, 1); push(16'hD002, 2, 2); push(16'hD003, 3, 3);
      fq = '{0, 1, 2, 3};
      run("ovf", 3, 1'b1);
      chk("ovf_nsp", 32'(next_stack_pointer), 32'd3);

      // RET on empty stack
      clear_mem();
      mem[0] = 16'hE001;
      fq = '{0};
      run("unf", 0, 1'b1);

      // PC wrap at 0xFFF, loop terminates by stack overflow
      clear_mem();
      mem[0] = 16'hD00A; mem[16'h00A] = 16'hCFFF; mem[16'hFFF] = 16'h1234;
      for (int k = 1; k <= 3; k++) begin
         push(16'hD00A, 16'h00A, k); push(16'hCFFF, 16'hFFF, k); push(16'h1234, 0, k);
         fq.push_back(0); fq.push_back(16'h00A); fq.push_back(16'hFFF);
      end
      fq.push_back(0);
      run("wrap", 9, 1'b1);

      // reset while a fetch is outstanding
      clear_mem();
      mem[0] = 16'h1000;
      mem_en = 1'b0;
      n_strobe = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!imem_req && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_req_seen", 32'(imem_req), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mid_req", 32'(imem_req), 32'd0);
      chk("mid_exe", 32'(execution_enable), 32'd0);
      chk("mid_ins", 32'(instruction), 32'd0);
      chk("mid_halted", 32'(halted), 32'd0);
      chk("mid_stkerr", 32'(stack_error), 32'd0);
      chk("mid_nsp", 32'(next_stack_pointer), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_en = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_no_strobe", 32'(n_strobe), 32'd0);
      chk("mid_idle_req", 32'(imem_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
